spi_master_arbiter: RTL and testbench

- Shares one spi Master instance between NUM_REQ requesters using round-robin arbitration.
- Latches the winning requester's slave select and tx byte and pulses the Master's start.
- Tracks the transfer through the Master's CS lines, then returns the received byte and a done pulse to the granted requester.
- Includes a watchdog that aborts hung transfers. Sits between client logic and the Master.

---
 rtl/spi_arb_pkg.sv | 17 +
 rtl/rr_arbiter.sv | 37 +++
 rtl/spi_master_arbiter.sv | 142 ++++++++++++++
 tb/tb_spi_master_arbiter.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_arb_pkg.sv
// Shared encodings for the SPI master arbiter: FSM states and the
// chip-select / slave-select constants it decodes.
package spi_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT_CS,
    ST_XFER,
    ST_FINISH,
    ST_ABORT
  } state_t;

  localparam logic [2:0] CS_IDLE       = 3'b111;
  localparam logic [1:0] SLAVE_INVALID = 2'b11;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first set req bit strictly above ptr, wrapping to bit 0.
// Purely combinational; the caller registers the result and advances ptr.
module rr_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [PTR_W-1:0]   idx,
  output logic               any
);

  logic [NUM_REQ-1:0] upper;
  logic [NUM_REQ-1:0] cand;

  always_comb begin
    upper = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      upper[i] = req[i] && (PTR_W'(i) > ptr);
    end
    // Nothing pending above the pointer means the search wraps to the bottom.
    cand = (|upper) ? upper : req;
    gnt  = '0;
    idx  = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (cand[i]) begin
        gnt    = '0;
        gnt[i] = 1'b1;
        idx    = PTR_W'(i);
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/spi_master_arbiter.sv
// Shares one SPI master among NUM_REQ clients: round-robin grant, latch, start
// pulse, CS-tracked completion, and a watchdog that resets a hung master.
module spi_master_arbiter
  import spi_arb_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [2*NUM_REQ-1:0]      req_slave,
  input  logic [DATA_W*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        done,
  output logic                      err,
  output logic [DATA_W-1:0]         rx_data,
  output logic                      m_reset,
  output logic                      m_start,
  output logic [1:0]                m_slaveSelect,
  output logic [DATA_W-1:0]         m_dataToSend,
  input  logic [DATA_W-1:0]         m_dataReceived,
  input  logic [2:0]                m_CS
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int TW    = $clog2(TIMEOUT + 1);

  state_t             state;
  logic [PTR_W-1:0]   rr_ptr;
  logic [TW-1:0]      timer;
  logic               abort_q;

  logic [NUM_REQ-1:0] pick;
  logic [PTR_W-1:0]   pick_idx;
  logic               pick_any;
  logic [1:0]         sel_slave;
  logic [DATA_W-1:0]  sel_data;
  logic               timer_expired;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr (
    .req (req),
    .ptr (rr_ptr),
    .gnt (pick),
    .idx (pick_idx),
    .any (pick_any)
  );

  always_comb begin
    sel_slave = '0;
    sel_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick[i]) begin
        sel_slave = req_slave[2*i +: 2];
        sel_data  = req_data[DATA_W*i +: DATA_W];
      end
    end
  end

  // Timer is cleared alongside the start pulse, so this fires TIMEOUT cycles after it.
  assign timer_expired = (timer == TW'(TIMEOUT - 1));

  assign m_reset = reset | abort_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      rr_ptr        <= PTR_W'(NUM_REQ - 1);
      timer         <= '0;
      abort_q       <= 1'b0;
      gnt           <= '0;
      done          <= '0;
      err           <= 1'b0;
      rx_data       <= '0;
      m_start       <= 1'b0;
      m_slaveSelect <= '0;
      m_dataToSend  <= '0;
    end else begin
      m_start <= 1'b0;
      done    <= '0;
      abort_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pick_any) begin
            gnt           <= pick;
            rr_ptr        <= pick_idx;
            m_slaveSelect <= sel_slave;
            m_dataToSend  <= sel_data;
            if (sel_slave == SLAVE_INVALID) begin
              err   <= 1'b1;
              done  <= pick;
              state <= ST_FINISH;
            end else begin
              state <= ST_LAUNCH;
            end
          end
        end
        ST_LAUNCH: begin
          m_start <= 1'b1;
          timer   <= '0;
          state   <= ST_WAIT_CS;
        end
        ST_WAIT_CS: begin
          timer <= timer + TW'(1);
          if (m_CS != CS_IDLE) begin
            state <= ST_XFER;
          end else if (timer_expired) begin
            abort_q <= 1'b1;
            state   <= ST_ABORT;
          end
        end
        ST_XFER: begin
          timer <= timer + TW'(1);
          if (m_CS == CS_IDLE) begin
            rx_data <= m_dataReceived;
            err     <= 1'b0;
            done    <= gnt;
            state   <= ST_FINISH;
          end else if (timer_expired) begin
            abort_q <= 1'b1;
            state   <= ST_ABORT;
          end
        end
        ST_ABORT: begin
          err   <= 1'b1;
          done  <= gnt;
          state <= ST_FINISH;
        end
        ST_FINISH: begin
          gnt   <= '0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_arbiter.sv
// Randomized bench for spi_master_arbiter with a behavioural SPI master and
// a round-robin reference model computed directly from the arbitration rules.
module tb_spi_master_arbiter;

  localparam int N  = 3;
  localparam int DW = 8;
  localparam int TO = 64;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    req = '0;
  logic [2*N-1:0]  req_slave = '0;
  logic [DW*N-1:0] req_data = '0;
  logic [N-1:0]    gnt;
  logic [N-1:0]    done;
  logic            err;
  logic [DW-1:0]   rx_data;
  logic            m_reset;
  logic            m_start;
  logic [1:0]      m_slaveSelect;
  logic [DW-1:0]   m_dataToSend;
  logic [DW-1:0]   m_dataReceived = '0;
  logic [2:0]      m_CS = 3'b111;

  int errors = 0;
  int checks = 0;

  spi_master_arbiter #(.NUM_REQ(N), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk            (clk),
    .reset          (reset),
    .req            (req),
    .req_slave      (req_slave),
    .req_data       (req_data),
    .gnt            (gnt),
    .done           (done),
    .err            (err),
    .rx_data        (rx_data),
    .m_reset        (m_reset),
    .m_start        (m_start),
    .m_slaveSelect  (m_slaveSelect),
    .m_dataToSend   (m_dataToSend),
    .m_dataReceived (m_dataReceived),
    .m_CS           (m_CS)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural SPI master: CS drops 2 cycles after start, stays low mdl_len cycles.
  logic          mdl_hang = 1'b0;
  int            mdl_len = 3;
  logic [DW-1:0] mdl_reply = '0;
  logic          busy = 1'b0;
  int            cnt = 0;
  logic [1:0]    mdl_slave = '0;
  logic [DW-1:0] last_tx = '0;
  int            start_cnt = 0;
  int            start_cyc = 0;
  int            mreset_cyc = 0;
  int            mreset_pulses = 0;
  int            onehot_viol = 0;

  always @(negedge clk) begin
    if (m_reset) begin
      busy = 1'b0;
      m_CS = 3'b111;
    end else if (m_start) begin
      start_cnt++;
      start_cyc = cyc;
      last_tx   = m_dataToSend;
      if (!mdl_hang) begin
        busy      = 1'b1;
        cnt       = 0;
        mdl_slave = m_slaveSelect;
      end
    end else if (busy) begin
      cnt++;
      if (cnt == 2) m_CS = ~(3'b001 << mdl_slave);
      if (cnt == 2 + mdl_len) begin
        m_CS           = 3'b111;
        m_dataReceived = mdl_reply;
        busy           = 1'b0;
      end
    end
    if (m_reset && !reset) begin
      mreset_cyc = cyc;
      mreset_pulses++;
    end
    if ($countones(gnt) > 1) onehot_viol++;
  end

  // Reference arbitration state.
  int            ref_last = N - 1;
  logic [DW-1:0] ref_rx = '0;

  function automatic int ref_pick(input logic [N-1:0] r, input int last);
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (last + k) % N;
      if (((r >> c) & 1) != 0) return c;
    end
    return -1;
  endfunction

  task automatic wait_done(output logic [N-1:0] d, output logic e,
                           output logic [DW-1:0] r, output logic ok);
    ok = 1'b0; d = '0; e = 1'b0; r = '0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(posedge clk); #1;
      if (|done) begin
        d = done; e = err; r = rx_data; ok = 1'b1;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    if (gnt !== '0) begin $display("FAIL reset_gnt got=%b want=0", gnt); errors++; end
    checks++;
    if (done !== '0 || err !== 1'b0) begin $display("FAIL reset_done got=%b/%b want=0/0", done, err); errors++; end
    checks++;
    if (rx_data !== '0 || m_start !== 1'b0) begin $display("FAIL reset_rx_start got=%h/%b want=0/0", rx_data, m_start); errors++; end
    checks++;
    if (m_slaveSelect !== 2'b00 || m_dataToSend !== '0) begin
      $display("FAIL reset_mlatch got=%b/%h want=0/0", m_slaveSelect, m_dataToSend); errors++;
    end
    checks++;
    if (m_reset !== 1'b1) begin $display("FAIL reset_mreset got=%b want=1", m_reset); errors++; end
    checks++;
    reset = 1'b0;
    @(posedge clk); #1;
    if (m_reset !== 1'b0 || gnt !== '0) begin $display("FAIL reset_release got=%b/%b want=0/0", m_reset, gnt); errors++; end
    checks++;
    ref_last = N - 1;
    ref_rx   = '0;
  endtask

  task automatic test_round_robin;
    int exp_order[4] = '{0, 1, 2, 0};
    logic [N-1:0] d; logic e; logic [DW-1:0] r; logic ok;
    logic [DW-1:0] rep;
    for (int i = 0; i < N; i++) begin
      req_slave[2*i +: 2] = 2'($urandom_range(0, 2));
      req_data[DW*i +: DW] = DW'($urandom);
    end
    req = '1;
    for (int t = 0; t < 4; t++) begin
      int w;
      rep = DW'($urandom);
      mdl_reply = rep;
      w = ref_pick(req, ref_last);
      wait_done(d, e, r, ok);
      if (!ok) begin $display("FAIL rr_timeout txn=%0d", t); errors++; end
      checks++;
      if (d !== N'(1 << exp_order[t]) || w != exp_order[t]) begin
        $display("FAIL rr_order txn=%0d got=%b want=%b", t, d, N'(1 << exp_order[t])); errors++;
      end
      checks++;
      if (e !== 1'b0 || r !== rep) begin $display("FAIL rr_data txn=%0d got=%b/%h want=0/%h", t, e, r, rep); errors++; end
      checks++;
      ref_last = w;
      ref_rx   = rep;
    end
    req = '0;
  endtask

  task automatic test_basic;
    logic [N-1:0] d; logic e; logic [DW-1:0] r; logic ok;
    int s0;
    s0 = start_cnt;
    req_slave[1:0] = 2'b00;
    req_data[DW-1:0] = 8'b01101001;
    mdl_reply = 8'b11011010;
    @(posedge clk); #1;
    req = 3'b001;
    @(posedge clk); #1;
    if (gnt !== 3'b001 || m_start !== 1'b0) begin $display("FAIL basic_gnt got=%b/%b want=001/0", gnt, m_start); errors++; end
    checks++;
    @(posedge clk); #1;
    if (m_start !== 1'b1) begin $display("FAIL basic_start got=%b want=1", m_start); errors++; end
    checks++;
    wait_done(d, e, r, ok);
    if (!ok || d !== 3'b001 || gnt !== 3'b001) begin $display("FAIL basic_done got=%b gnt=%b want=001", d, gnt); errors++; end
    checks++;
    if (e !== 1'b0 || r !== 8'b11011010) begin $display("FAIL basic_rx got=%b/%h want=0/da", e, r); errors++; end
    checks++;
    if (start_cnt - s0 != 1 || last_tx !== 8'b01101001) begin
      $display("FAIL basic_tx starts=%0d tx=%h want=1/69", start_cnt - s0, last_tx); errors++;
    end
    checks++;
    req = '0;
    ref_last = 0;
    ref_rx   = 8'b11011010;
  endtask

  task automatic test_invalid_slave;
    logic seen;
    int s0;
    s0 = start_cnt;
    seen = 1'b0;
    req_slave[3:2] = 2'b11;
    req_data[2*DW-1:DW] = DW'($urandom);
    @(posedge clk); #1;
    req = 3'b010;
    @(posedge clk); #1;
    if (gnt !== 3'b010) begin $display("FAIL inv_gnt got=%b want=010", gnt); errors++; end
    checks++;
    for (int i = 0; i < 4 && !seen; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      if (|done) begin
        seen = 1'b1;
        if (done !== 3'b010 || err !== 1'b1) begin $display("FAIL inv_done got=%b/%b want=010/1", done, err); errors++; end
        checks++;
        if (rx_data !== ref_rx) begin $display("FAIL inv_rx got=%h want=%h", rx_data, ref_rx); errors++; end
        checks++;
      end
    end
    if (!seen) begin $display("FAIL inv_nodone got=none want=done within 3"); errors++; end
    checks++;
    req = '0;
    repeat (3) @(posedge clk);
    #1;
    if (start_cnt != s0) begin $display("FAIL inv_start got=%0d want=0", start_cnt - s0); errors++; end
    checks++;
    ref_last = 1;
  endtask

  task automatic test_timeout;
    logic [N-1:0] d; logic e; logic [DW-1:0] r; logic ok;
    int p0;
    p0 = mreset_pulses;
    mdl_hang = 1'b1;
    req_slave[1:0] = 2'b01;
    req_data[DW-1:0] = DW'($urandom);
    @(posedge clk); #1;
    req = 3'b001;
    wait_done(d, e, r, ok);
    if (!ok || d !== 3'b001 || e !== 1'b1) begin $display("FAIL to_done got=%b/%b want=001/1", d, e); errors++; end
    checks++;
    if (mreset_pulses - p0 != 1 || mreset_cyc - start_cyc != TO) begin
      $display("FAIL to_mreset pulses=%0d delay=%0d want=1/%0d", mreset_pulses - p0, mreset_cyc - start_cyc, TO); errors++;
    end
    checks++;
    if (r !== ref_rx) begin $display("FAIL to_rx got=%h want=%h", r, ref_rx); errors++; end
    checks++;
    req = '0;
    mdl_hang = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    if (gnt !== '0 || done !== '0) begin $display("FAIL to_idle got=%b/%b want=0/0", gnt, done); errors++; end
    checks++;
    ref_last = 0;
  endtask

  task automatic test_reset_mid;
    logic [N-1:0] d; logic e; logic [DW-1:0] r; logic ok;
    int dcount;
    logic xfer;
    xfer = 1'b0;
    dcount = 0;
    mdl_len = 12;
    req_slave[1:0] = 2'b10;
    req_data[DW-1:0] = DW'($urandom);
    @(posedge clk); #1;
    req = 3'b001;
    for (int i = 0; i < 50 && !xfer; i++) begin
      @(posedge clk); #1;
      if (m_CS !== 3'b111) xfer = 1'b1;
    end
    if (!xfer) begin $display("FAIL rm_xfer got=idle want=active"); errors++; end
    checks++;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    if (gnt !== '0 || m_start !== 1'b0 || done !== '0 || rx_data !== '0) begin
      $display("FAIL rm_state got=%b/%b/%b/%h want=0/0/0/0", gnt, m_start, done, rx_data); errors++;
    end
    checks++;
    req = '0;
    reset = 1'b0;
    ref_last = N - 1;
    ref_rx = '0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (|done) dcount++;
    end
    if (dcount != 0) begin $display("FAIL rm_nodone got=%0d want=0", dcount); errors++; end
    checks++;
    mdl_len = 3;
    mdl_reply = DW'($urandom);
    req = 3'b001;
    wait_done(d, e, r, ok);
    if (!ok || d !== 3'b001 || e !== 1'b0 || r !== mdl_reply) begin
      $display("FAIL rm_fresh got=%b/%b/%h want=001/0/%h", d, e, r, mdl_reply); errors++;
    end
    checks++;
    req = '0;
    ref_last = 0;
    ref_rx = mdl_reply;
  endtask

  task automatic test_latch;
    logic [N-1:0] d; logic e; logic [DW-1:0] r; logic ok;
    logic [DW-1:0] orig;
    logic xfer;
    xfer = 1'b0;
    orig = DW'($urandom);
    mdl_len = 8;
    mdl_reply = DW'($urandom);
    req_slave[5:4] = 2'b01;
    req_data[3*DW-1:2*DW] = orig;
    @(posedge clk); #1;
    req = 3'b100;
    for (int i = 0; i < 50 && !xfer; i++) begin
      @(posedge clk); #1;
      if (m_CS !== 3'b111) xfer = 1'b1;
    end
    req_data[3*DW-1:2*DW] = ~orig;
    req_slave[5:4] = 2'b11;
    req = '0;
    wait_done(d, e, r, ok);
    if (!ok || d !== 3'b100 || e !== 1'b0) begin $display("FAIL latch_done got=%b/%b want=100/0", d, e); errors++; end
    checks++;
    if (last_tx !== orig || m_dataToSend !== orig || r !== mdl_reply) begin
      $display("FAIL latch_data tx=%h rx=%h want=%h/%h", last_tx, r, orig, mdl_reply); errors++;
    end
    checks++;
    mdl_len = 3;
    ref_last = 2;
    ref_rx = mdl_reply;
  endtask

  task automatic test_random;
    logic [N-1:0] d; logic e; logic [DW-1:0] r; logic ok;
    for (int t = 0; t < 24; t++) begin
      logic [N-1:0] mask;
      logic [DW-1:0] rep;
      int w;
      logic exp_err;
      logic [DW-1:0] exp_rx;
      mask = N'($urandom_range(1, (1 << N) - 1));
      for (int i = 0; i < N; i++) begin
        req_slave[2*i +: 2] = 2'($urandom_range(0, 3));
        req_data[DW*i +: DW] = DW'($urandom);
      end
      rep = DW'($urandom);
      mdl_reply = rep;
      mdl_len = $urandom_range(1, 6);
      w = ref_pick(mask, ref_last);
      exp_err = (((req_slave >> (2 * w)) & 3) == 3);
      exp_rx = exp_err ? ref_rx : rep;
      req = mask;
      wait_done(d, e, r, ok);
      if (!ok || d !== N'(1 << w)) begin $display("FAIL rnd_winner txn=%0d req=%b got=%b want=%b", t, mask, d, N'(1 << w)); errors++; end
      checks++;
      if (e !== exp_err || r !== exp_rx) begin $display("FAIL rnd_result txn=%0d got=%b/%h want=%b/%h", t, e, r, exp_err, exp_rx); errors++; end
      checks++;
      if (!exp_err && last_tx !== DW'(req_data >> (DW * w))) begin
        $display("FAIL rnd_tx txn=%0d got=%h want=%h", t, last_tx, DW'(req_data >> (DW * w))); errors++;
      end
      checks++;
      ref_last = w;
      ref_rx = exp_rx;
    end
    req = '0;
    mdl_len = 3;
  endtask

  task automatic test_single;
    logic [N-1:0] d; logic e; logic [DW-1:0] r; logic ok;
    req_slave[3:2] = 2'b00;
    req = 3'b010;
    for (int t = 0; t < 3; t++) begin
      mdl_reply = DW'($urandom);
      wait_done(d, e, r, ok);
      if (!ok || d !== 3'b010 || r !== mdl_reply) begin $display("FAIL single txn=%0d got=%b/%h want=010/%h", t, d, r, mdl_reply); errors++; end
      checks++;
    end
    req = '0;
    repeat (3) @(posedge clk);
    #1;
    if (onehot_viol != 0) begin $display("FAIL onehot got=%0d want=0", onehot_viol); errors++; end
    checks++;
  endtask

  initial begin
    test_reset;
    test_round_robin;
    test_basic;
    test_invalid_slave;
    test_timeout;
    test_reset_mid;
    test_latch;
    test_random;
    test_single;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
